// File: rtl/cpu_bus_pkg.sv
// Shared types and helpers for the register-bus arbiter slice.
package cpu_bus_pkg;

  typedef enum logic {IDLE, DRIVE} bus_state_e;

  localparam int DEFAULT_TIMEOUT = 16;
  localparam int MAX_REGS        = 256;

  // Callers size the result down to their own register count with a width cast.
  function automatic logic [MAX_REGS-1:0] onehot_idx(input logic [7:0] idx);
    onehot_idx      = '0;
    onehot_idx[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted req at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          valid
);

  logic [PW-1:0] j;

  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    j     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      j = PW'((32'(ptr) + i) % N);
      if (!valid && req[j]) begin
        gnt[j] = 1'b1;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_bus_arbiter.sv
// Round-robin owner of the shared register read buses and load strobes,
// with a turnaround idle cycle between transactions and a hang timeout.
module reg_bus_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = $clog2(NUM_REGS),
  parameter int TIMEOUT  = DEFAULT_TIMEOUT
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             use_a,
  input  logic [NUM_REQ-1:0]             use_b,
  input  logic [NUM_REQ-1:0]             wr_en,
  input  logic [NUM_REQ-1:0][IDX_W-1:0]  src_a,
  input  logic [NUM_REQ-1:0][IDX_W-1:0]  src_b,
  input  logic [NUM_REQ-1:0][IDX_W-1:0]  dst,
  input  logic                           done,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [NUM_REGS-1:0]            oe_a,
  output logic [NUM_REGS-1:0]            oe_b,
  output logic [NUM_REGS-1:0]            ld,
  output logic [NUM_REQ-1:0]             ack,
  output logic [NUM_REQ-1:0]             err,
  output logic                           busy
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT);

  bus_state_e           state_q, state_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [NUM_REQ-1:0]   err_q, err_d;
  logic [NUM_REGS-1:0]  oe_a_q, oe_a_d;
  logic [NUM_REGS-1:0]  oe_b_q, oe_b_d;
  logic                 lat_wr_q, lat_wr_d;
  logic [IDX_W-1:0]     lat_dst_q, lat_dst_d;

  logic [NUM_REQ-1:0]   arb_gnt;
  logic                 arb_valid;
  logic [PW-1:0]        win_idx;
  logic                 bad_idx;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req   (req),
    .ptr   (ptr_q),
    .gnt   (arb_gnt),
    .valid (arb_valid)
  );

  always_comb begin
    win_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++)
      if (arb_gnt[i]) win_idx = PW'(i);
  end

  assign bad_idx = (use_a[win_idx] && (int'(src_a[win_idx]) >= NUM_REGS)) ||
                   (use_b[win_idx] && (int'(src_b[win_idx]) >= NUM_REGS)) ||
                   (wr_en[win_idx] && (int'(dst[win_idx])   >= NUM_REGS));

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    oe_a_d    = oe_a_q;
    oe_b_d    = oe_b_q;
    lat_wr_d  = lat_wr_q;
    lat_dst_d = lat_dst_q;
    ack_d     = '0;
    err_d     = '0;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          ptr_d = (32'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;
          if (bad_idx) begin
            err_d = arb_gnt;
          end else begin
            state_d   = DRIVE;
            gnt_d     = arb_gnt;
            cnt_d     = '0;
            lat_wr_d  = wr_en[win_idx];
            lat_dst_d = dst[win_idx];
            oe_a_d    = use_a[win_idx] ? NUM_REGS'(onehot_idx(8'(src_a[win_idx]))) : '0;
            oe_b_d    = use_b[win_idx] ? NUM_REGS'(onehot_idx(8'(src_b[win_idx]))) : '0;
          end
        end
      end
      DRIVE: begin
        // done takes priority over an expiring timeout in the same cycle
        if (done || (32'(cnt_q) == TIMEOUT - 1)) begin
          state_d = IDLE;
          gnt_d   = '0;
          oe_a_d  = '0;
          oe_b_d  = '0;
          cnt_d   = '0;
          if (done) ack_d = gnt_q;
          else      err_d = gnt_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      oe_a_q    <= '0;
      oe_b_q    <= '0;
      ack_q     <= '0;
      err_q     <= '0;
      lat_wr_q  <= 1'b0;
      lat_dst_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      oe_a_q    <= oe_a_d;
      oe_b_q    <= oe_b_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      lat_wr_q  <= lat_wr_d;
      lat_dst_q <= lat_dst_d;
    end
  end

  assign gnt  = gnt_q;
  assign oe_a = oe_a_q;
  assign oe_b = oe_b_q;
  assign ack  = ack_q;
  assign err  = err_q;
  assign busy = (state_q == DRIVE);
  assign ld   = (state_q == DRIVE && done && lat_wr_q) ?
                NUM_REGS'(onehot_idx(8'(lat_dst_q))) : '0;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed bench for reg_bus_arbiter: 4 requesters, 12 registers, timeout 16.
module tb_reg_bus_arbiter;

  localparam int NRQ = 4;
  localparam int NRG = 12;
  localparam int IW  = 4;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NRQ-1:0]           req, use_a, use_b, wr_en;
  logic [NRQ-1:0][IW-1:0]   src_a, src_b, dst;
  logic                     done;
  logic [NRQ-1:0]           gnt, ack, err;
  logic [NRG-1:0]           oe_a, oe_b, ld;
  logic                     busy;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  reg_bus_arbiter #(.NUM_REQ(NRQ), .NUM_REGS(NRG), .IDX_W(IW), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req(req), .use_a(use_a), .use_b(use_b), .wr_en(wr_en),
    .src_a(src_a), .src_b(src_b), .dst(dst), .done(done),
    .gnt(gnt), .oe_a(oe_a), .oe_b(oe_b), .ld(ld), .ack(ack), .err(err), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_gnt"},  32'(gnt),  32'h0);
    chk({tag, "_oe_a"}, 32'(oe_a), 32'h0);
    chk({tag, "_oe_b"}, 32'(oe_b), 32'h0);
    chk({tag, "_ld"},   32'(ld),   32'h0);
    chk({tag, "_ack"},  32'(ack),  32'h0);
    chk({tag, "_err"},  32'(err),  32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
  endtask

  initial begin
    rst = 1'b1; req = '0; use_a = '0; use_b = '0; wr_en = '0;
    src_a = '0; src_b = '0; dst = '0; done = 1'b0;
    #1;
    chk_quiet("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    chk_quiet("idle_noreq");

    // Round-robin, all requesting, done held high
    for (int i = 0; i < NRQ; i++) src_a[i] = IW'(i + 1);
    use_a = 4'b1111; req = 4'b1111; done = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rr_gnt",  32'(gnt),  32'(1 << (k % 4)));
      chk("rr_oe_a", 32'(oe_a), 32'(1 << ((k % 4) + 1)));
      tick();
      chk("rr_gap_gnt",  32'(gnt),  32'h0);
      chk("rr_gap_oe_a", 32'(oe_a), 32'h0);
      chk("rr_ack",      32'(ack),  32'(1 << (k % 4)));
      if (k == 4) req = '0;
    end
    done = 1'b0;

    // Single write by requester 1 (pointer now 1)
    use_a = 4'b0010; use_b = 4'b0010; wr_en = 4'b0010;
    src_a[1] = 4'd3; src_b[1] = 4'd5; dst[1] = 4'd7; req = 4'b0010;
    tick();
    chk("wr_gnt",  32'(gnt),  32'h2);
    chk("wr_busy", 32'(busy), 32'h1);
    chk("wr_oe_a1", 32'(oe_a), 32'h008);
    chk("wr_oe_b1", 32'(oe_b), 32'h020);
    chk("wr_ld1",  32'(ld),   32'h0);
    tick();
    chk("wr_oe_a2", 32'(oe_a), 32'h008);
    chk("wr_oe_b2", 32'(oe_b), 32'h020);
    req = '0; src_a[1] = 4'd0; dst[1] = 4'd1;
    tick();
    chk("wr_oe_a3", 32'(oe_a), 32'h008);
    chk("wr_gnt3",  32'(gnt),  32'h2);
    done = 1'b1;
    #1;
    chk("wr_ld_done", 32'(ld), 32'h080);
    tick();
    done = 1'b0;
    chk("wr_ack",   32'(ack),  32'h2);
    chk("wr_ld_after", 32'(ld), 32'h0);
    chk("wr_oe_a_ta",  32'(oe_a), 32'h0);
    chk("wr_oe_b_ta",  32'(oe_b), 32'h0);
    chk("wr_busy_ta",  32'(busy), 32'h0);

    // Timeout by requester 2 (pointer now 2)
    use_a = 4'b0100; use_b = '0; wr_en = 4'b0100;
    src_a[2] = 4'd3; dst[2] = 4'd4; req = 4'b0100;
    for (int c = 1; c <= 16; c++) begin
      tick();
      chk("to_busy", 32'(busy), 32'h1);
      chk("to_gnt",  32'(gnt),  32'h4);
      chk("to_ld",   32'(ld),   32'h0);
    end
    tick();
    chk("to_err",  32'(err),  32'h4);
    chk("to_ack",  32'(ack),  32'h0);
    chk("to_busy_end", 32'(busy), 32'h0);
    chk("to_ld_end",   32'(ld),   32'h0);
    use_a = '0; wr_en = 4'b0001; dst[0] = 4'd11; req = 4'b1001;
    tick();
    chk("to_next_gnt", 32'(gnt), 32'h8);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("to_next_ack", 32'(ack), 32'h8);
    req = 4'b0001;

    // Done coincides with the 16th DRIVE cycle (requester 0)
    for (int c = 1; c <= 16; c++) begin
      tick();
      chk("col_busy", 32'(busy), 32'h1);
    end
    done = 1'b1;
    #1;
    chk("col_ld", 32'(ld), 32'h800);
    tick();
    done = 1'b0; req = '0;
    chk("col_ack", 32'(ack), 32'h1);
    chk("col_err", 32'(err), 32'h0);

    // Bad destination index on requester 1 (pointer now 1)
    wr_en = 4'b0110; dst[1] = 4'd13; dst[2] = 4'd4; req = 4'b0010;
    tick();
    chk("bad_err",  32'(err),  32'h2);
    chk("bad_gnt",  32'(gnt),  32'h0);
    chk("bad_oe_a", 32'(oe_a), 32'h0);
    chk("bad_busy", 32'(busy), 32'h0);
    req = 4'b0110;
    tick();
    chk("bad_ptr_gnt", 32'(gnt), 32'h4);
    req = '0; done = 1'b1;
    tick();
    done = 1'b0;
    chk("bad_ack", 32'(ack), 32'h4);

    // Asynchronous reset mid-DRIVE (requester 3 at pointer 3)
    use_a = 4'b1000; src_a[3] = 4'd3; wr_en = 4'b1000; dst[3] = 4'd4; req = 4'b1000;
    tick();
    chk("rst_pre_oe_a", 32'(oe_a), 32'h008);
    req = '0;
    tick();
    done = 1'b1;
    #1;
    chk("rst_pre_ld", 32'(ld), 32'h010);
    rst = 1'b1;
    #1;
    chk_quiet("rst_mid");
    done = 1'b0;
    tick();
    rst = 1'b0;
    use_a = '0; wr_en = '0; req = 4'b1010;
    tick();
    chk("rst_ptr0_gnt", 32'(gnt), 32'h2);
    req = 4'b1000; done = 1'b1;
    tick();
    done = 1'b0;
    chk("rst_ack1", 32'(ack), 32'h2);
    tick();
    chk("rst_gnt3", 32'(gnt), 32'h8);
    done = 1'b1;
    tick();
    done = 1'b0; req = '0;
    chk("rst_ack3", 32'(ack), 32'h8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_bus_arbiter.md
Name: reg_bus_arbiter

Overview:
- Shares the two tri-state register read buses (a, b) and the register load strobes between several requesters, such as the fetch unit, execute unit and debug port.
- Arbitrates round-robin and drives one-hot output-enable and load vectors into a bank of NUM_REGS cpu_reg instances.
- Holds the bus until the consumer signals done; a timeout aborts a hung consumer.
- Guarantees at most one driver per bus and one dead cycle between transactions, which is the tri-state turnaround.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- NUM_REGS, 16, number of cpu_reg instances on the buses
- IDX_W, $clog2(NUM_REGS), register index width
- TIMEOUT, 16, maximum DRIVE cycles without done before abort (>=2)

Ports:
- clk  in  1  clock, all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- req  in  NUM_REQ  request per requester; held high until ack or err
- use_a  in  NUM_REQ  requester i needs bus a
- use_b  in  NUM_REQ  requester i needs bus b
- wr_en  in  NUM_REQ  requester i writes dst on completion
- src_a  in  NUM_REQ x IDX_W  bus-a source index per requester
- src_b  in  NUM_REQ x IDX_W  bus-b source index per requester
- dst  in  NUM_REQ x IDX_W  destination index per requester
- done  in  1  consumer (ALU/memory) result valid on the in bus this cycle
- gnt  out  NUM_REQ  one-hot grant, high for the whole DRIVE phase
- oe_a  out  NUM_REGS  one-hot-or-zero enable for bus a
- oe_b  out  NUM_REGS  one-hot-or-zero enable for bus b
- ld  out  NUM_REGS  one-hot-or-zero load strobe
- ack  out  NUM_REQ  one-cycle pulse: transaction completed
- err  out  NUM_REQ  one-cycle pulse: transaction rejected or timed out
- busy  out  1  state is DRIVE

Behaviour:
- Reset (async, any time, including mid-DRIVE):
  - state=IDLE, rr pointer=0, timeout counter=0.
  - gnt, oe_a, oe_b, ld, ack, err and busy all 0 immediately, with no wait for a clock edge.
- States: IDLE, DRIVE.
- IDLE:
  - Pick the first asserted req at or after the pointer, wrapping modulo NUM_REQ.
  - At the posedge, latch that requester's use/src/dst/wr_en fields and enter DRIVE.
  - Set the pointer to winner+1 mod NUM_REQ.
- Rejection in IDLE:
  - Trigger: any used index (use_a→src_a, use_b→src_b, wr_en→dst) is >= NUM_REGS.
  - Response: stay in IDLE, pulse err[winner] the next cycle, advance the pointer.
- DRIVE:
  - gnt[winner]=1 and busy=1.
  - oe_a=onehot(src_a) if use_a, else 0; oe_b likewise. Both are registered, driven from latched fields, and stable for the whole phase.
- ld is combinational: onehot(dst) & {NUM_REGS{done & wr_en_latched & state==DRIVE}}. It is therefore high only in the done cycle, and the register captures on that posedge.
- done in DRIVE:
  - Enter IDLE at the posedge; ack[winner] pulses the following cycle.
  - All oe go to 0 in that IDLE cycle, which is the mandatory turnaround.
- Timing: minimum transaction is 2 cycles (DRIVE with done, then IDLE); back-to-back grants are spaced by exactly one idle cycle.
- Timeout:
  - The counter increments each DRIVE cycle without done.
  - When it reaches TIMEOUT-1 and done=0, enter IDLE, pulse err[winner] and assert no ld.
  - done and timeout in the same cycle: done wins, so ack is issued, ld is asserted and there is no err.
  - The counter clears on DRIVE entry.
- Request fields: req dropped or fields changed during DRIVE are ignored; the latched values complete the transaction.
- Index overlap: src_a==src_b is legal (both enables set for the same register); dst==src is legal (read-modify-write).
- No winner: in IDLE with req=0, all outputs stay 0.
- Invariants: $onehot0(oe_a), $onehot0(oe_b), $onehot0(ld), $onehot0(gnt), $onehot0(ack|err).

Decomposition:
- Package cpu_bus_pkg holds:
  - typedef enum logic {IDLE, DRIVE} bus_state_e
  - function onehot_idx(idx) returning NUM_REGS bits
  - localparam for the default TIMEOUT
- Sub-module rr_arbiter (parameter N):
  - Inputs: req, ptr. Output: one-hot winner plus a valid flag.
  - Purely combinational; the pointer register lives in reg_bus_arbiter.

Test Plan:
- Single write: req[1] with src_a=3, src_b=5, dst=7, wr_en=1; done asserted in the 3rd DRIVE cycle.
  - Expect oe_a=0x0008 and oe_b=0x0020 for 3 cycles.
  - Expect ld=0x0080 only in the done cycle, then ack[1] 1 cycle later.
- Round-robin: req=4'b1111 held; done every DRIVE cycle.
  - Expect grant order 0,1,2,3,0.
  - Expect one all-zero oe cycle between each grant.
- Timeout: req[2], done never asserted, TIMEOUT=16.
  - Expect DRIVE for exactly 16 cycles, then err[2] and no ld.
  - Expect the next grant to go to requester 3.
- Done/timeout collision: done in the 16th DRIVE cycle.
  - Expect ack and ld both asserted; no err.
- Bad index: NUM_REGS=12, dst=13, wr_en=1.
  - Expect err pulse, no gnt and no oe; pointer advances.
- Reset: rst asserted mid-DRIVE with oe_a=0x0008.
  - Expect all outputs 0 in the same cycle, without a clock edge.
  - After release with req[3] pending, expect gnt[3] with pointer 0 behaviour.
